// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Optional MUX4_ARB_PARK_EN: keep sel and out parked on the last owner when idle.

module mux_4to1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = a;
        unique case (sel)
            2'd0: y = a;
            2'd1: y = b;
            2'd2: y = c;
            2'd3: y = d;
        endcase
    end

endmodule

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [3:0] out,
    output logic       out_valid
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    win;
    logic [3:0]    mux_y;

    // {found, index} of the first set bit scanning upward from start
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic [1:0] start
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (r[idx] && !res[2]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // while granting, ptr_q is cur+1, so the owner is searched last
    assign win = pick(req, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (win[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win[1:0];
                    sel_d   = win[1:0];
                    ptr_d   = win[1:0] + 2'd1;
                    hold_d  = HW'(1);
                end
            end
            GRANT: begin
                if (req[sel_q] && hold_q < HMAX) begin
                    hold_d = hold_q + HW'(1);
                end else if (win[2]) begin
                    gnt_d  = 4'b0001 << win[1:0];
                    sel_d  = win[1:0];
                    ptr_d  = win[1:0] + 2'd1;
                    hold_d = HW'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    hold_d  = '0;
`ifdef MUX4_ARB_PARK_EN
                    sel_d   = sel_q;
`else
                    sel_d   = 2'b00;
`endif
                end
            end
        endcase
    end

    mux_4to1 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = |gnt_q;

`ifdef MUX4_ARB_PARK_EN
    assign out = mux_y;
`else
    assign out = out_valid ? mux_y : 4'b0000;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter with a queue-based reference model.
// Honours MUX4_ARB_PARK_EN for the idle sel/out expectations.

module tb_mux4_rr_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] out;
    logic       out_valid;

    mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic [3:0] out;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference: owner index (-1 = nobody), burst length, next priority
    int m_owner = -1;
    int m_cnt   = 0;
    int m_prio  = 0;
    int m_park  = 0;

    task automatic check(input string nm, input logic [3:0] act,
                         input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_prio  = 0;
        m_park  = 0;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] oa,
                         input logic [3:0] ob, input logic [3:0] oc,
                         input logic [3:0] od);
        logic [3:0] ops [4];
        exp_t e;
        int   start;
        int   w;
        bit   keep;
        req = r; a = oa; b = ob; c = oc; d = od;
        ops = '{oa, ob, oc, od};
        keep = (m_owner >= 0) && r[m_owner] && (m_cnt < MH);
        if (keep) begin
            m_cnt++;
        end else begin
            start = (m_owner >= 0) ? (m_owner + 1) % 4 : m_prio;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && r[(start + k) % 4]) w = (start + k) % 4;
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                m_prio  = (w + 1) % 4;
                m_park  = w;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        if (m_owner >= 0) begin
            e.gnt = 4'(1 << m_owner);
            e.sel = 2'(m_owner);
            e.vld = 1'b1;
            e.out = ops[m_owner];
        end else begin
            e.gnt = 4'b0000;
            e.vld = 1'b0;
`ifdef MUX4_ARB_PARK_EN
            e.sel = 2'(m_park);
            e.out = ops[m_park];
`else
            e.sel = 2'b00;
            e.out = 4'b0000;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] oa,
                        input logic [3:0] ob, input logic [3:0] oc,
                        input logic [3:0] od);
        @(negedge clk);
        drive(r, oa, ob, oc, od);
    endtask

    task automatic step_rand(input logic [3:0] r);
        step(r, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // monitor: pops one expectation per edge after the DUT settles
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("gnt", gnt, e.gnt);
                check("sel", {2'b00, sel}, {2'b00, e.sel});
                check("out_valid", {3'b000, out_valid}, {3'b000, e.vld});
                check("out", out, e.out);
            end
        end
    end

    logic [3:0] r_prev;

    initial begin
        rst_n = 1'b0;
        req = 4'b1111;
        a = 4'h0; b = 4'h5; c = 4'h3; d = 4'h9;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", {2'b00, sel}, 4'b0000);
        check("rst_vld", {3'b000, out_valid}, 4'b0000);
        check("rst_out", out, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(4'b1111, 4'h0, 4'h5, 4'h3, 4'h9);
        repeat (16) step(4'b1111, 4'h1, 4'h2, 4'h4, 4'h8);

        repeat (3) step(4'b0000, 4'h1, 4'h2, 4'h4, 4'h8);
        repeat (10) step(4'b0100, 4'hA, 4'hB, 4'h3, 4'hD);
        repeat (2) step(4'b0000, 4'hA, 4'hB, 4'h3, 4'hD);

        repeat (2) step(4'b1010, 4'h0, 4'h6, 4'h0, 4'hE);
        repeat (3) step(4'b1000, 4'h0, 4'h6, 4'h0, 4'hE);
        step(4'b1000, 4'h0, 4'h6, 4'h0, 4'hE);

        // asynchronous reset in the middle of the d burst
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_gnt", gnt, 4'b0000);
        check("mid_sel", {2'b00, sel}, 4'b0000);
        check("mid_vld", {3'b000, out_valid}, 4'b0000);
`ifdef MUX4_ARB_PARK_EN
        check("mid_out", out, a);
`else
        check("mid_out", out, 4'b0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(4'b1001, 4'h7, 4'h1, 4'h2, 4'hC);
        repeat (6) step(4'b1001, 4'h7, 4'h1, 4'h2, 4'hC);

        repeat (2) step(4'b0100, 4'h1, 4'h2, 4'h6, 4'h4);
        repeat (3) step(4'b0000, 4'h1, 4'h2, 4'h6, 4'h4);

        r_prev = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r_prev = 4'($urandom);
            step_rand(r_prev);
        end
        repeat (3) step_rand(4'b0000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
